reg_lock_tracker: RTL

- Tracks pending register writes for instructions issued by the instruction launcher.
- Generates the per-register `locks` vector that the launcher consumes as `locks_i`. It is the producer end of the lock interface that the launcher reads.
- A launch fire with a destination register increments that register's pending count. A writeback event decrements it.
- Sits between the launcher output handshake and the execution-unit writeback bus.

---
 rtl/maverickOne_pkg.sv | 10 +
 rtl/reg_lock_tracker_if.sv | 27 ++
 rtl/reg_lock_counter.sv | 43 ++++
 rtl/reg_lock_tracker.sv | 81 ++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// rtl/maverickOne_pkg.sv - shared core sizing and register/lock types
package maverickOne_pkg;

  localparam int NUM_REGS        = 32;
  localparam int NUM_OUTSTANDING = 8;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]         locks_t;

endpackage

// File: rtl/reg_lock_tracker_if.sv
// rtl/reg_lock_tracker_if.sv - launch/writeback bus and lock outputs of the tracker
interface reg_lock_tracker_if
  import maverickOne_pkg::*;
#(
  parameter int MAX_TOTAL = NUM_OUTSTANDING
);

  reg_idx_t                         launch_rd_i;
  logic                             launch_valid_i;
  logic                             launch_ready_o;
  reg_idx_t                         wb_rd_i;
  logic                             wb_valid_i;
  locks_t                           locks_o;
  logic [$clog2(MAX_TOTAL+1)-1:0]   outstanding_o;
  logic                             underflow_o;

  modport master (
    output launch_rd_i, launch_valid_i, wb_rd_i, wb_valid_i,
    input  launch_ready_o, locks_o, outstanding_o, underflow_o
  );

  modport slave (
    input  launch_rd_i, launch_valid_i, wb_rd_i, wb_valid_i,
    output launch_ready_o, locks_o, outstanding_o, underflow_o
  );

endinterface

// File: rtl/reg_lock_counter.sv
// rtl/reg_lock_counter.sv - saturating pending-write counter for one register
module reg_lock_counter #(
  parameter int MAX = 3
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clear_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic not_full_o,
  output logic underflow_o
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A simultaneous inc and dec always nets to zero, even from an empty count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && cnt_q != CW'(MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero_o   = (cnt_q != '0);
  assign not_full_o  = (cnt_q != CW'(MAX));
  assign underflow_o = dec_i & ~inc_i & (cnt_q == '0);

endmodule

// File: rtl/reg_lock_tracker.sv
// rtl/reg_lock_tracker.sv - per-register pending-write tracker producing the launcher lock vector
module reg_lock_tracker
  import maverickOne_pkg::*;
#(
  parameter int NUM_REGS    = maverickOne_pkg::NUM_REGS,
  parameter int MAX_PER_REG = 3,
  parameter int MAX_TOTAL   = NUM_OUTSTANDING
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic               clear_i,
  reg_lock_tracker_if.slave  bus
);

  localparam int TW = $clog2(MAX_TOTAL + 1);

  logic [NUM_REGS-1:0] nonzero, not_full, uf_try;
  logic                launch_fire, wb_fire, inc_total, dec_total, total_room;
  logic [TW-1:0]       total_q, total_d;
  logic                underflow_q, underflow_d;

  assign nonzero[0]  = 1'b0;
  assign not_full[0] = 1'b1;
  assign uf_try[0]   = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = launch_fire & (bus.launch_rd_i == reg_idx_t'(r));
    assign dec = wb_fire     & (bus.wb_rd_i     == reg_idx_t'(r));

    reg_lock_counter #(.MAX(MAX_PER_REG)) u_cnt (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .clear_i     (clear_i),
      .inc_i       (inc),
      .dec_i       (dec),
      .nonzero_o   (nonzero[r]),
      .not_full_o  (not_full[r]),
      .underflow_o (uf_try[r])
    );
  end

  // Ready ignores same-cycle writebacks so wb stays off this path; gated by reset
  // so it reads 0 while held and 1 as soon as reset releases.
  assign total_room         = (total_q < TW'(MAX_TOTAL));
  assign bus.launch_ready_o = arst_ni & ~clear_i &
                              ((bus.launch_rd_i == '0) |
                               (not_full[bus.launch_rd_i] & total_room));

  assign launch_fire = bus.launch_valid_i & bus.launch_ready_o;
  assign wb_fire     = bus.wb_valid_i & ~clear_i;
  assign inc_total   = launch_fire & (bus.launch_rd_i != '0);
  assign dec_total   = wb_fire & (bus.wb_rd_i != '0) & ~uf_try[bus.wb_rd_i];

  always_comb begin
    total_d     = total_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      total_d     = '0;
      underflow_d = 1'b0;
    end else begin
      total_d     = total_q + TW'(inc_total) - TW'(dec_total);
      underflow_d = underflow_q | (|uf_try);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      total_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      total_q     <= total_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.locks_o       = locks_t'(nonzero);
  assign bus.outstanding_o = total_q;
  assign bus.underflow_o   = underflow_q;

endmodule
